// File: rtl/rand_delay_ctrl.sv
// Randomised one-shot delay: a free-running 7-bit LFSR picks the tick count at each accepted trigger.
// Define RAND_DELAY_MIN_EN to clamp the captured delay to at least MIN_DELAY ticks.
module rand_delay_ctrl #(
  parameter int unsigned MIN_DELAY = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       tick,
  input  logic       abort,
  output logic       busy,
  output logic       time_out,
  output logic [6:0] delay_val,
  output logic [6:0] count_rem,
  output logic [6:0] lfsr_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef RAND_DELAY_MIN_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif
  localparam logic [6:0] FLOOR = 7'(MIN_DELAY);

  state_t     state;
  logic [6:0] cap;

  // Captured value comes from the LFSR as it stands before the capturing edge.
  always_comb begin
    cap = lfsr_out;
    if (MIN_EN && (lfsr_out < FLOOR)) cap = FLOOR;
  end

  // x^7 + x^6 + 1, runs every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_out <= 7'h01;
    else      lfsr_out <= {lfsr_out[5:0], lfsr_out[6] ^ lfsr_out[5]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      delay_val <= '0;
      count_rem <= '0;
      busy      <= 1'b0;
      time_out  <= 1'b0;
    end else begin
      time_out <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            delay_val <= cap;
            count_rem <= cap;
            busy      <= 1'b1;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            if (count_rem > 7'd1) begin
              count_rem <= count_rem - 7'd1;
            end else begin
              count_rem <= '0;
              time_out  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_delay_ctrl.sv
// Directed bench for rand_delay_ctrl: LFSR sequence, delay timing, sparse ticks, abort and async reset.
// Build with +define+RAND_DELAY_MIN_EN to exercise the MIN_DELAY floor (MIN_DELAY = 16).
module tb_rand_delay_ctrl;

  logic       clk;
  logic       rst;
  logic       trigger;
  logic       tick;
  logic       abort;
  logic       busy;
  logic       time_out;
  logic [6:0] delay_val;
  logic [6:0] count_rem;
  logic [6:0] lfsr_out;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  rand_delay_ctrl #(.MIN_DELAY(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .tick      (tick),
    .abort     (abort),
    .busy      (busy),
    .time_out  (time_out),
    .delay_val (delay_val),
    .count_rem (count_rem),
    .lfsr_out  (lfsr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_c(input logic [6:0] l);
`ifdef RAND_DELAY_MIN_EN
    return (l < 7'd16) ? 7'd16 : l;
`else
    return l;
`endif
  endfunction

  task automatic wait_lfsr(input logic [6:0] v);
    for (int i = 0; i < 300 && lfsr_out != v; i++) step();
    check("wait_lfsr", {25'd0, lfsr_out}, {25'd0, v});
  endtask

  logic [6:0] seq_tbl [8];
  logic [6:0] c;
  logic [6:0] v0;
  logic [6:0] exp_rem;
  int unsigned zeros;
  int unsigned pulses;
  int unsigned ticks_seen;
  int unsigned late_bad;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    seq_tbl   = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03, 7'h06};
    rst = 1'b0; trigger = 1'b0; tick = 1'b0; abort = 1'b0;

    // Reset state, held across clock edges
    repeat (2) step();
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_to",    {31'd0, time_out},  32'd0);
    check("rst_dval",  {25'd0, delay_val}, 32'd0);
    check("rst_crem",  {25'd0, count_rem}, 32'd0);
    check("rst_lfsr",  {25'd0, lfsr_out},  32'h01);

    // LFSR free-run sequence and period
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("lfsr_seq", {25'd0, lfsr_out}, {25'd0, seq_tbl[i]});
    end
    v0 = lfsr_out;
    zeros = 0;
    for (int i = 0; i < 127; i++) begin
      step();
      if (lfsr_out == 7'h00) zeros++;
    end
    check("lfsr_zero", zeros, 0);
    check("lfsr_period", {25'd0, lfsr_out}, {25'd0, v0});

    // Delay of lfsr=08 with tick held high; first cycle after capture is cycle 1
    wait_lfsr(7'h08);
    c = exp_c(7'h08);
    tick = 1'b1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("d8_dval", {25'd0, delay_val}, {25'd0, c});
    check("d8_busy", {31'd0, busy}, 32'd1);
    pulses = 0;
    late_bad = 0;
    for (int n = 1; n <= int'(c); n++) begin
      if (count_rem != c - 7'(n) + 7'd1) late_bad++;
      if (time_out) pulses++;
      step();
    end
    check("d8_crem_seq", late_bad, 0);
    check("d8_to_at_c1", {31'd0, time_out}, 32'd1);
    check("d8_crem0",    {25'd0, count_rem}, 32'd0);
    check("d8_busy_done", {31'd0, busy}, 32'd1);
    pulses += time_out ? 1 : 0;
    step();
    pulses += time_out ? 1 : 0;
    check("d8_pulses", pulses, 1);
    check("d8_idle_busy", {31'd0, busy}, 32'd0);
    tick = 1'b0;

    // Capture values at lfsr=04 and lfsr=41
    wait_lfsr(7'h04);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("cap_04", {25'd0, delay_val}, {25'd0, exp_c(7'h04)});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {31'd0, busy}, 32'd0);
    wait_lfsr(7'h41);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("cap_41", {25'd0, delay_val}, 32'd65);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Trigger together with abort in IDLE starts a delay
    trigger = 1'b1; abort = 1'b1;
    step();
    trigger = 1'b0; abort = 1'b0;
    check("trig_abort_idle", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Sparse ticks: every third cycle
    wait_lfsr(7'h08);
    c = exp_c(7'h08);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    exp_rem = c;
    ticks_seen = 0;
    late_bad = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick = (cyc % 3 == 2);
      step();
      if (tick) begin
        ticks_seen++;
        exp_rem = exp_rem - 7'd1;
      end
      if (exp_rem == 7'd0) break;
      if (count_rem != exp_rem || time_out) late_bad++;
    end
    tick = 1'b0;
    check("sparse_crem", late_bad, 0);
    check("sparse_ticks", ticks_seen, {25'd0, c});
    check("sparse_to", {31'd0, time_out}, 32'd1);
    step();
    check("sparse_to_end", {31'd0, time_out}, 32'd0);

    // Abort at count_rem=3, second trigger ignored during COUNT
    wait_lfsr(7'h08);
    c = exp_c(7'h08);
    tick = 1'b1; trigger = 1'b1;
    step();
    step();
    trigger = 1'b0;
    check("retrig_dval", {25'd0, delay_val}, {25'd0, c});
    for (int i = 0; i < 200 && count_rem != 7'd3; i++) step();
    check("reach_3", {25'd0, count_rem}, 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_crem", {25'd0, count_rem}, 32'd3);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      pulses += time_out ? 1 : 0;
      pulses += busy ? 1 : 0;
      step();
    end
    check("abort_quiet", pulses, 0);
    tick = 1'b0;

    // Asynchronous reset mid-COUNT, between clock edges
    wait_lfsr(7'h08);
    tick = 1'b1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy},      32'd0);
    check("arst_to",   {31'd0, time_out},  32'd0);
    check("arst_dval", {25'd0, delay_val}, 32'd0);
    check("arst_crem", {25'd0, count_rem}, 32'd0);
    check("arst_lfsr", {25'd0, lfsr_out},  32'h01);
    step();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      pulses += time_out ? 1 : 0;
    end
    check("arst_no_to", pulses, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
